fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the program counter and the instruction-memory fetch port of the MIPS core.
//  Selects the next PC (sequential +4, taken branch, jump or exception vector) and runs a
//  req/ack handshake with instruction memory, handing each fetched instruction, tagged with
//  its PC, to decode. Sits between the PC register/adder datapath and IMEM.
//  Handles stall, squash on redirect and fetch timeout.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC loaded on reset
//  EXC_VEC    32'h8000_0180  PC loaded on exception or fetch timeout
//  MAX_WAIT   8              consecutive un-acked request cycles before abort (>=1)
// PORTS
//  CLK         in   1   clock, rising edge
//  RESET       in   1   reset, asynchronous, active-high
//  stall       in   1   decode cannot accept; no new fetch is started
//  br_taken    in   1   taken-branch redirect, 1-cycle pulse
//  br_offset   in   16  signed word offset of the branch
//  jmp_valid   in   1   jump redirect, 1-cycle pulse
//  jmp_target  in   26  jump instr_index
//  rd_pc       in   32  PC of the redirecting instruction
//  exc         in   1   exception redirect, 1-cycle pulse
//  imem_req    out  1   fetch request
//  imem_addr   out  32  fetch address; stable while imem_req=1
//  imem_ack    in   1   IMEM has returned imem_rdata this cycle
//  imem_rdata  in   32  instruction word
//  instr_valid out  1   1-cycle pulse: instr/instr_pc valid
//  instr       out  32  fetched instruction
//  instr_pc    out  32  PC of instr
//  pc          out  32  current fetch PC
//  fetch_err   out  1   1-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (async): state=IDLE; pc=imem_addr=RESET_VEC; imem_req=instr_valid=fetch_err=0;
//   instr=instr_pc=0; wait counter=0; pending redirect cleared.
//  States: IDLE, FETCH, HOLD.
//   IDLE: imem_req=0; next cycle goes to FETCH (HOLD if stall=1). Exactly one IDLE cycle after reset.
//   FETCH: imem_req=1, imem_addr=pc; ack sampled on each rising edge, including the first FETCH cycle.
//    On ack: if not squashed, register instr=imem_rdata, instr_pc=pc, instr_valid=1 next cycle.
//     Then pc<=next PC; stay in FETCH if stall=0, otherwise go to HOLD.
//     With ack held high, throughput is one instruction per cycle.
//    No ack: imem_req and imem_addr hold; wait counter increments.
//    Timeout: on the MAX_WAIT-th consecutive un-acked cycle:
//     imem_req=0 and fetch_err=1 the next cycle; pc<=EXC_VEC; state to IDLE.
//   HOLD: imem_req=0; while stall=1, remain in HOLD; when stall=0, go to FETCH next cycle.
//   stall never withdraws an asserted imem_req; it only blocks the next request.
//  Next PC, priority exc > jmp_valid > br_taken > sequential:
//   exc: EXC_VEC
//   jump: {rd_pc+4 [31:28], jmp_target, 2'b00}
//   branch: rd_pc + 4 + (sext(br_offset) << 2), modulo 2^32
//   sequential: pc + 4, wraps 32'hFFFF_FFFC -> 0
//  Redirect when idle: a redirect in IDLE/HOLD, or in FETCH with ack in the same cycle,
//   loads pc directly.
//  Redirect mid-request: in FETCH without ack, the target goes to a pending register
//   (a later higher-priority redirect overwrites it).
//   The outstanding request completes; its data is squashed (instr_valid stays 0).
//   pc then takes the pending target.
//  Squash: an ack coinciding with any redirect is squashed as well.
//  Timeout vs redirect: a timeout abort overrides any pending redirect.
//  pc output mirrors the internal pc register.
// TESTING
//  1 Reset, ack=1 every cycle, imem_rdata=addr^32'hA5A5_A5A5
//    -> imem_addr 0,4,8,C; instr_valid each cycle, instr_pc matching
//  2 Ack delayed 3 cycles at pc=0x4 -> imem_req high 4 cycles, addr 0x4 stable, one instr_valid, then 0x8
//  3 br_taken, rd_pc=0x10, br_offset=-2, during un-acked fetch
//    -> that ack is squashed; next imem_addr=0x0C
//  4 exc and jmp_valid in the same cycle (jmp_target=0x40) -> next imem_addr=32'h8000_0180
//  5 No ack for 8 cycles (MAX_WAIT=8) -> fetch_err pulses once, req drops one cycle,
//    fetch resumes at 32'h8000_0180
//  6 stall=1 during an outstanding req, then RESET asserted mid-wait
//    -> req held until ack, then HOLD with req=0; RESET returns all outputs to reset values
//    asynchronously; fetch resumes at RESET_VEC

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - MIPS PC sequencing and instruction-memory fetch handshake
// Picks the next PC, issues one IMEM request at a time and hands tagged instructions to decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0180,
    parameter int          MAX_WAIT  = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_target,
    input  logic [31:0] rd_pc,
    input  logic        exc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        fetch_err
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic [CW-1:0] wait_q, wait_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_rank_q, pend_rank_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        redir_now;
    logic [1:0]  redir_rank;
    logic [31:0] redir_tgt;
    logic [31:0] rd_pc_inc;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        redir_wins;
    logic        timeout;

    assign rd_pc_inc = rd_pc + 32'd4;
    assign br_tgt    = rd_pc_inc + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign jmp_tgt   = {rd_pc_inc[31:28], jmp_target, 2'b00};
    assign redir_now = exc | jmp_valid | br_taken;

    // Rank encodes redirect priority so a queued target is only displaced by an equal or stronger one.
    always_comb begin
        redir_rank = 2'd0;
        redir_tgt  = pc_q + 32'd4;
        if (exc) begin
            redir_rank = 2'd3;
            redir_tgt  = EXC_VEC;
        end else if (jmp_valid) begin
            redir_rank = 2'd2;
            redir_tgt  = jmp_tgt;
        end else if (br_taken) begin
            redir_rank = 2'd1;
            redir_tgt  = br_tgt;
        end
    end

    assign redir_wins = redir_now && (!pend_valid_q || (redir_rank >= pend_rank_q));
    assign timeout    = (wait_q == CW'(MAX_WAIT - 1));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        wait_d        = wait_q;
        pend_valid_d  = pend_valid_q;
        pend_rank_d   = pend_rank_q;
        pend_pc_d     = pend_pc_q;

        case (state_q)
            S_IDLE, S_HOLD: begin
                wait_d = '0;
                if (redir_now) begin
                    pc_d = redir_tgt;
                end
                state_d = stall ? S_HOLD : S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    // Data returned alongside or after a redirect belongs to the wrong path.
                    if (!redir_now && !pend_valid_q) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end
                    if (redir_wins) begin
                        pc_d = redir_tgt;
                    end else if (pend_valid_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                    pend_valid_d = 1'b0;
                    pend_rank_d  = 2'd0;
                    wait_d       = '0;
                    state_d      = stall ? S_HOLD : S_FETCH;
                end else if (timeout) begin
                    pc_d         = EXC_VEC;
                    fetch_err_d  = 1'b1;
                    pend_valid_d = 1'b0;
                    pend_rank_d  = 2'd0;
                    wait_d       = '0;
                    state_d      = S_IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                    if (redir_wins) begin
                        pend_valid_d = 1'b1;
                        pend_rank_d  = redir_rank;
                        pend_pc_d    = redir_tgt;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_VEC;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_rank_q   <= 2'd0;
            pend_pc_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            wait_q        <= wait_d;
            pend_valid_q  <= pend_valid_d;
            pend_rank_q   <= pend_rank_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h8000_0180;
    localparam logic [31:0] XMASK     = 32'hA5A5_A5A5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jmp_valid;
    logic [25:0] jmp_target;
    logic [31:0] rd_pc;
    logic        exc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        fetch_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_sequencer #(
        .RESET_VEC(RESET_VEC),
        .EXC_VEC  (EXC_VEC),
        .MAX_WAIT (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .rd_pc      (rd_pc),
        .exc        (exc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    always #5 CLK = ~CLK;

    assign imem_rdata = imem_addr ^ XMASK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = a ^ XMASK;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        RESET      = 1'b1;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_offset  = 16'd0;
        jmp_valid  = 1'b0;
        jmp_target = 26'd0;
        rd_pc      = 32'd0;
        exc        = 1'b0;
        imem_ack   = 1'b0;
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic release_reset();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({imem_req, instr_valid, fetch_err} !== 3'b000)
            $display("FAIL reset_ctl: got req/valid/err=%b required 000", {imem_req, instr_valid, fetch_err});
        else n_pass++;
        n_checks++;
        if ({pc, imem_addr} !== {RESET_VEC, RESET_VEC})
            $display("FAIL reset_pc: got pc=%h addr=%h required %h", pc, imem_addr, RESET_VEC);
        else n_pass++;
        n_checks++;
        if ({instr, instr_pc} !== 64'd0)
            $display("FAIL reset_instr: got instr=%h instr_pc=%h required 0", instr, instr_pc);
        else n_pass++;
        release_reset();
        tick();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_VEC})
            $display("FAIL reset_first_fetch: got req=%b addr=%h required 1 %h", imem_req, imem_addr, RESET_VEC);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        release_reset();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL b2b_idle_req: got %b required 0", imem_req);
        else n_pass++;
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(32'(4 * k));
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                n_checks++;
                if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)})
                    $display("FAIL b2b_addr%0d: got req=%b addr=%h required 1 %h", k, imem_req, imem_addr, 32'(4 * k));
                else n_pass++;
            end
            if (k >= 1) begin
                n_checks++;
                if (!instr_valid || exp_q.size() == 0) begin
                    $display("FAIL b2b_valid%0d: got valid=%b required 1", k, instr_valid);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_pc, instr} !== {e.pc, e.data})
                        $display("FAIL b2b_instr%0d: got pc=%h instr=%h required %h %h", k, instr_pc, instr, e.pc, e.data);
                    else n_pass++;
                end
            end
            if (k == 4) imem_ack = 1'b0;
        end
        tick();
        n_checks++;
        if (instr_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL b2b_extra: got valid=%b pending=%0d required 0 0", instr_valid, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_ack_delay();
        exp_t e;
        int   held;
        int   valids;
        apply_reset();
        release_reset();
        imem_ack = 1'b1;
        push_exp(32'h0);
        push_exp(32'h4);
        tick();
        held   = 0;
        valids = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (imem_req && imem_addr == 32'h4) held++;
            if (instr_valid) begin
                valids++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL delay_unexpected: got pc=%h required none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_pc, instr} !== {e.pc, e.data})
                        $display("FAIL delay_instr: got pc=%h instr=%h required %h %h", instr_pc, instr, e.pc, e.data);
                    else n_pass++;
                end
            end
            if (k == 5) begin
                n_checks++;
                if ({imem_req, imem_addr} !== {1'b1, 32'h8})
                    $display("FAIL delay_next: got req=%b addr=%h required 1 00000008", imem_req, imem_addr);
                else n_pass++;
            end
            imem_ack = (k == 4);
        end
        n_checks++;
        if (held != 4) $display("FAIL delay_held: got %0d required 4", held);
        else n_pass++;
        n_checks++;
        if (valids != 2 || exp_q.size() != 0)
            $display("FAIL delay_count: got valids=%0d pending=%0d required 2 0", valids, exp_q.size());
        else n_pass++;
        imem_ack = 1'b0;
    endtask

    task automatic test_branch_squash();
        exp_t e;
        apply_reset();
        release_reset();
        tick();
        br_taken  = 1'b1;
        rd_pc     = 32'h10;
        br_offset = 16'hFFFE;
        tick();
        br_taken = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL br_hold: got req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        else n_pass++;
        imem_ack = 1'b1;
        tick();
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL br_squash: got valid=%b required 0", instr_valid);
        else n_pass++;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hC})
            $display("FAIL br_target: got req=%b addr=%h required 1 0000000c", imem_req, imem_addr);
        else n_pass++;
        push_exp(32'hC);
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (!instr_valid || exp_q.size() == 0) begin
            $display("FAIL br_valid: got valid=%b required 1", instr_valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr_pc, instr} !== {e.pc, e.data})
                $display("FAIL br_instr: got pc=%h instr=%h required %h %h", instr_pc, instr, e.pc, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_exc_jump();
        exp_t e;
        apply_reset();
        release_reset();
        jmp_valid  = 1'b1;
        rd_pc      = 32'h1000_0000;
        jmp_target = 26'h40;
        tick();
        jmp_valid = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h1000_0100})
            $display("FAIL jmp_idle: got req=%b addr=%h required 1 10000100", imem_req, imem_addr);
        else n_pass++;
        exc        = 1'b1;
        jmp_valid  = 1'b1;
        jmp_target = 26'h40;
        rd_pc      = 32'h200;
        imem_ack   = 1'b1;
        tick();
        exc       = 1'b0;
        jmp_valid = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL exc_squash: got valid=%b required 0", instr_valid);
        else n_pass++;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, EXC_VEC})
            $display("FAIL exc_prio: got req=%b addr=%h required 1 %h", imem_req, imem_addr, EXC_VEC);
        else n_pass++;
        push_exp(EXC_VEC);
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if (!instr_valid || exp_q.size() == 0) begin
            $display("FAIL exc_valid: got valid=%b required 1", instr_valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr_pc, instr} !== {e.pc, e.data})
                $display("FAIL exc_instr: got pc=%h instr=%h required %h %h", instr_pc, instr, e.pc, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   reqs;
        int   errs;
        apply_reset();
        release_reset();
        reqs = 0;
        errs = 0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            br_taken = 1'b0;
            if (fetch_err) errs++;
            if (k <= 8 && imem_req && imem_addr == 32'h0) reqs++;
            if (k == 3) begin
                br_taken  = 1'b1;
                rd_pc     = 32'h40;
                br_offset = 16'd4;
            end
            if (k == 9) begin
                n_checks++;
                if ({imem_req, fetch_err, pc} !== {2'b01, EXC_VEC})
                    $display("FAIL to_abort: got req=%b err=%b pc=%h required 0 1 %h", imem_req, fetch_err, pc, EXC_VEC);
                else n_pass++;
            end
            if (k == 10) begin
                n_checks++;
                if ({imem_req, imem_addr} !== {1'b1, EXC_VEC})
                    $display("FAIL to_resume: got req=%b addr=%h required 1 %h", imem_req, imem_addr, EXC_VEC);
                else n_pass++;
                imem_ack = 1'b1;
                push_exp(EXC_VEC);
            end
            if (k == 11) begin
                imem_ack = 1'b0;
                n_checks++;
                if (!instr_valid || exp_q.size() == 0) begin
                    $display("FAIL to_valid: got valid=%b required 1", instr_valid);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr_pc, instr} !== {e.pc, e.data})
                        $display("FAIL to_instr: got pc=%h instr=%h required %h %h", instr_pc, instr, e.pc, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (reqs != 8) $display("FAIL to_wait: got %0d req cycles required 8", reqs);
        else n_pass++;
        n_checks++;
        if (errs != 1) $display("FAIL to_err_pulse: got %0d required 1", errs);
        else n_pass++;
    endtask

    task automatic test_wrap();
        exp_t e;
        apply_reset();
        release_reset();
        jmp_valid  = 1'b1;
        rd_pc      = 32'hEFFF_FFFC;
        jmp_target = 26'h3FF_FFFF;
        tick();
        jmp_valid = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_top: got req=%b addr=%h required 1 fffffffc", imem_req, imem_addr);
        else n_pass++;
        imem_ack = 1'b1;
        push_exp(32'hFFFF_FFFC);
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL wrap_zero: got req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        else n_pass++;
        n_checks++;
        if (!instr_valid || exp_q.size() == 0) begin
            $display("FAIL wrap_valid: got valid=%b required 1", instr_valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr_pc, instr} !== {e.pc, e.data})
                $display("FAIL wrap_instr: got pc=%h instr=%h required %h %h", instr_pc, instr, e.pc, e.data);
            else n_pass++;
        end
    endtask

    task automatic test_stall_reset();
        exp_t e;
        apply_reset();
        release_reset();
        tick();
        stall = 1'b1;
        tick();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL stall_keep_req: got req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        else n_pass++;
        imem_ack = 1'b1;
        push_exp(32'h0);
        tick();
        imem_ack = 1'b0;
        n_checks++;
        if ({imem_req, pc} !== {1'b0, 32'h4})
            $display("FAIL stall_hold: got req=%b pc=%h required 0 00000004", imem_req, pc);
        else n_pass++;
        n_checks++;
        if (!instr_valid || exp_q.size() == 0) begin
            $display("FAIL stall_valid: got valid=%b required 1", instr_valid);
        end else begin
            e = exp_q.pop_front();
            if ({instr_pc, instr} !== {e.pc, e.data})
                $display("FAIL stall_instr: got pc=%h instr=%h required %h %h", instr_pc, instr, e.pc, e.data);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL stall_hold2: got req=%b required 0", imem_req);
        else n_pass++;
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({imem_req, instr_valid, fetch_err, pc, imem_addr, instr, instr_pc} !==
            {3'b000, RESET_VEC, RESET_VEC, 64'd0})
            $display("FAIL async_reset: got req=%b pc=%h addr=%h instr=%h instr_pc=%h required 0 %h %h 0 0",
                     imem_req, pc, imem_addr, instr, instr_pc, RESET_VEC, RESET_VEC);
        else n_pass++;
        stall = 1'b0;
        tick();
        release_reset();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL rst_idle: got req=%b required 0", imem_req);
        else n_pass++;
        tick();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_VEC})
            $display("FAIL rst_resume: got req=%b addr=%h required 1 %h", imem_req, imem_addr, RESET_VEC);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ack_delay();
        test_branch_squash();
        test_exc_jump();
        test_timeout();
        test_wrap();
        test_stall_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
